systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_pkg.sv | 19 +
 rtl/systolic_feeder_if.sv | 30 +++
 rtl/feeder_matrix_bank.sv | 30 +++
 rtl/systolic_feeder.sv | 82 ++++++++
 tb/tb_systolic_feeder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared sizing, FSM encoding and helpers for the systolic array feeder.
package systolic_pkg;

    localparam int N      = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FEED  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Matrix-load port, run control and skewed array feed bus of systolic_feeder.
interface systolic_feeder_if #(
    parameter int N      = systolic_pkg::N,
    parameter int DATA_W = systolic_pkg::DATA_W
);
    localparam int IDX_W = systolic_pkg::clog2_min1(N);

    logic                  wr_en;
    logic                  wr_sel;
    logic [IDX_W-1:0]      wr_row;
    logic [IDX_W-1:0]      wr_col;
    logic [DATA_W-1:0]     wr_data;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  array_clr;
    logic [N*DATA_W-1:0]   row_out;
    logic [N*DATA_W-1:0]   col_out;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, done, array_clr, row_out, col_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, done, array_clr, row_out, col_out
    );

endinterface

// File: rtl/feeder_matrix_bank.sv
// N x N register bank with one write port; element (r,c) sits at flat slot r*N+c.
module feeder_matrix_bank #(
    parameter int  N      = systolic_pkg::N,
    parameter int  DATA_W = systolic_pkg::DATA_W,
    localparam int IDX_W  = systolic_pkg::clog2_min1(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_row,
    input  logic [IDX_W-1:0]        wr_col,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [N*N*DATA_W-1:0]   rd_bus
);
    import systolic_pkg::*;

    logic [N-1:0][N-1:0][DATA_W-1:0] mem;

    // NOTE: the bank is plain flops, so it takes the async reset like any other state; a RAM macro could not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (wr_en && (int'(wr_row) < N) && (int'(wr_col) < N)) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    assign rd_bus = mem;

endmodule

// File: rtl/systolic_feeder.sv
// Loads A and B, then streams them diagonally skewed into an N x N systolic array.
module systolic_feeder #(
    parameter int N      = systolic_pkg::N,
    parameter int DATA_W = systolic_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    systolic_feeder_if.slave  bus
);
    import systolic_pkg::*;

    localparam int T_LAST = 3 * N - 3;
    localparam int CNT_W  = clog2_min1(3 * N - 2);

    state_t             state, state_next;
    logic [CNT_W-1:0]   t, t_next;
    logic               wr_a, wr_b;
    logic [N*N*DATA_W-1:0] a_bus, b_bus;

    // Banks only accept writes while idle so a run always sees a stable matrix.
    assign wr_a = bus.wr_en && (state == S_IDLE) && !bus.wr_sel;
    assign wr_b = bus.wr_en && (state == S_IDLE) &&  bus.wr_sel;

    feeder_matrix_bank #(.N(N), .DATA_W(DATA_W)) u_bank_a (
        .clk(clk), .rst(rst), .wr_en(wr_a), .wr_row(bus.wr_row),
        .wr_col(bus.wr_col), .wr_data(bus.wr_data), .rd_bus(a_bus)
    );

    feeder_matrix_bank #(.N(N), .DATA_W(DATA_W)) u_bank_b (
        .clk(clk), .rst(rst), .wr_en(wr_b), .wr_row(bus.wr_row),
        .wr_col(bus.wr_col), .wr_data(bus.wr_data), .rd_bus(b_bus)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            t     <= '0;
        end else begin
            state <= state_next;
            t     <= t_next;
        end
    end

    // NOTE: defaults come first so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        t_next     = '0;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_CLEAR;
            S_CLEAR: state_next = S_FEED;
            S_FEED: begin
                if (t == CNT_W'(T_LAST)) state_next = S_DONE;
                else                     t_next     = t + 1'b1;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.busy      = (state == S_CLEAR) || (state == S_FEED);
    assign bus.done      = (state == S_DONE);
    assign bus.array_clr = (state == S_CLEAR);

    // Row i and column j are delayed by i (resp. j) cycles so operands meet at PE(i,j).
    always_comb begin
        int k;
        k           = 0;
        bus.row_out = '0;
        bus.col_out = '0;
        if (state == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                k = int'(t) - i;
                if (k >= 0 && k < N) begin
                    bus.row_out[i*DATA_W +: DATA_W] = a_bus[(i*N + k)*DATA_W +: DATA_W];
                    bus.col_out[i*DATA_W +: DATA_W] = b_bus[(k*N + i)*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench: drives systolic_feeder into a behavioural PE array and checks the products.
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int IDX_W = clog2_min1(N);

    typedef logic [N-1:0][N-1:0][DATA_W-1:0] mat_t;
    typedef struct packed {
        mat_t a;
        mat_t b;
        mat_t c;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [5];

    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .DATA_W(DATA_W)) bus ();
    systolic_feeder #(.N(N), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Output-stationary PE grid: in1 flows right, in2 flows down, 8-bit wrapping MAC.
    mat_t pe_acc, pe_h, pe_v;

    function automatic logic [DATA_W-1:0] pe_in1(input int i, input int j);
        return (j == 0) ? bus.row_out[i*DATA_W +: DATA_W] : pe_h[i][j-1];
    endfunction

    function automatic logic [DATA_W-1:0] pe_in2(input int i, input int j);
        return (i == 0) ? bus.col_out[j*DATA_W +: DATA_W] : pe_v[i-1][j];
    endfunction

    always @(posedge clk) begin
        if (bus.array_clr) begin
            pe_acc <= '0;
            pe_h   <= '0;
            pe_v   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pe_acc[i][j] <= pe_acc[i][j] + DATA_W'(pe_in1(i, j) * pe_in2(i, j));
                    pe_h[i][j]   <= pe_in1(i, j);
                    pe_v[i][j]   <= pe_in2(i, j);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] row_sl(input int i);
        return bus.row_out[i*DATA_W +: DATA_W];
    endfunction

    task automatic write_elem(input bit sel, input int r, input int c, input logic [DATA_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = r[IDX_W-1:0];
        bus.wr_col  = c[IDX_W-1:0];
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                write_elem(1'b0, i, j, v.a[i][j]);
                write_elem(1'b1, i, j, v.b[i][j]);
            end
        end
    endtask

    // Issues one start and watches a fixed 14-cycle window; cycle 1 is the one after the start edge.
    task automatic run_and_watch(input bit pulse_again, input bit write9,
                                 output int done_at, output int busy_n, output int done_n,
                                 output bit saw9, output bit nonzero);
        done_at = -1;
        busy_n  = 0;
        done_n  = 0;
        saw9    = 1'b0;
        nonzero = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (row_sl(2) == DATA_W'(9)) saw9 = 1'b1;
            if (bus.row_out != '0 || bus.col_out != '0) nonzero = 1'b1;
            bus.start   = pulse_again && (c == 4);
            bus.wr_en   = write9 && (c == 4);
            bus.wr_sel  = 1'b0;
            bus.wr_row  = IDX_W'(2);
            bus.wr_col  = IDX_W'(2);
            bus.wr_data = DATA_W'(9);
            tick();
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic check_products(input string tag, input mat_t exp);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s pe(%0d,%0d)", tag, i, j), 64'(pe_acc[i][j]), 64'(exp[i][j]));
    endtask

    initial begin
        int done_at, busy_n, done_n, dseen;
        bit saw9, nonzero;

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                vecs[0].a[i][j] = DATA_W'(1);
                vecs[0].b[i][j] = DATA_W'(2);
                vecs[0].c[i][j] = DATA_W'(6);
                vecs[1].a[i][j] = (i == j) ? DATA_W'(1) : DATA_W'(0);
                vecs[1].b[i][j] = DATA_W'(3*i + j + 1);
                vecs[1].c[i][j] = DATA_W'(3*i + j + 1);
                vecs[2].a[i][j] = DATA_W'(1);
                vecs[2].b[i][j] = (i == j) ? DATA_W'(1) : DATA_W'(0);
                vecs[2].c[i][j] = DATA_W'(1);
                vecs[3].a[i][j] = DATA_W'(16);
                vecs[3].b[i][j] = DATA_W'(5);
                vecs[3].c[i][j] = DATA_W'(240);
                vecs[4].a[i][j] = DATA_W'(i + 1);
                vecs[4].b[i][j] = DATA_W'(1);
                vecs[4].c[i][j] = DATA_W'(3*(i + 1));
            end
        end

        rst = 1'b0;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_data = '0; bus.start = 1'b0;
        tick(); tick();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset array_clr", 64'(bus.array_clr), 64'd0);
        check("reset row_out", 64'(bus.row_out), 64'd0);
        check("reset col_out", 64'(bus.col_out), 64'd0);
        rst = 1'b1;
        tick();

        // Skew check; A[1][0] is written on the same edge that samples start.
        write_elem(1'b0, 0, 0, DATA_W'(5));
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = IDX_W'(1); bus.wr_col = IDX_W'(0);
        bus.wr_data = DATA_W'(7); bus.start = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        check("clear array_clr", 64'(bus.array_clr), 64'd1);
        check("clear busy", 64'(bus.busy), 64'd1);
        check("clear row_out", 64'(bus.row_out), 64'd0);
        tick();
        check("t0 row0", 64'(row_sl(0)), 64'd5);
        check("t0 row1", 64'(row_sl(1)), 64'd0);
        check("t0 array_clr", 64'(bus.array_clr), 64'd0);
        tick();
        check("t1 row1", 64'(row_sl(1)), 64'd7);
        check("t1 row0", 64'(row_sl(0)), 64'd0);
        repeat (10) tick();

        for (int v = 0; v < 5; v++) begin
            load_vec(vecs[v]);
            run_and_watch(1'b0, 1'b0, done_at, busy_n, done_n, saw9, nonzero);
            check($sformatf("vec%0d done cycle", v), 64'(done_at), 64'd9);
            check($sformatf("vec%0d busy cycles", v), 64'(busy_n), 64'd8);
            check($sformatf("vec%0d done pulses", v), 64'(done_n), 64'd1);
            check($sformatf("vec%0d idle feed", v), 64'({bus.row_out, bus.col_out}), 64'd0);
            check_products($sformatf("vec%0d", v), vecs[v].c);
        end

        // Write attempted mid-run must be dropped (banks still hold vecs[4]).
        run_and_watch(1'b0, 1'b1, done_at, busy_n, done_n, saw9, nonzero);
        check("wr in feed saw9", 64'(saw9), 64'd0);
        check_products("wr in feed", vecs[4].c);
        run_and_watch(1'b0, 1'b0, done_at, busy_n, done_n, saw9, nonzero);
        check("rerun saw9", 64'(saw9), 64'd0);
        check("rerun done cycle", 64'(done_at), 64'd9);
        check_products("rerun", vecs[4].c);

        run_and_watch(1'b1, 1'b0, done_at, busy_n, done_n, saw9, nonzero);
        check("restart busy cycles", 64'(busy_n), 64'd8);
        check("restart done pulses", 64'(done_n), 64'd1);

        // Reset at FEED t=3 abandons the run and wipes both banks.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check("pre-reset busy", 64'(bus.busy), 64'd1);
        check("pre-reset row1", 64'(row_sl(1)), 64'd2);
        rst = 1'b0;
        #1;
        check("mid reset busy", 64'(bus.busy), 64'd0);
        check("mid reset feed", 64'({bus.row_out, bus.col_out}), 64'd0);
        check("mid reset array_clr", 64'(bus.array_clr), 64'd0);
        dseen = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.done) dseen++;
            tick();
        end
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (bus.done) dseen++;
            tick();
        end
        check("mid reset done pulses", 64'(dseen), 64'd0);
        run_and_watch(1'b0, 1'b0, done_at, busy_n, done_n, saw9, nonzero);
        check("post reset nonzero feed", 64'(nonzero), 64'd0);
        check("post reset done cycle", 64'(done_at), 64'd9);
        check("post reset products", 64'(pe_acc), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
